// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single BCD digit adder with decimal carry correction.
// BCD_DIGIT_CHECK_EN adds the 'invalid' output flagging a non-decimal operand digit.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic               invalid
`endif
);

  logic [DIGIT_W:0] raw;

  // Correction wraps modulo 16, so invalid digits still yield a defined pattern.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
    if (raw > {1'b0, BCD_MAX}) begin
      s  = raw[DIGIT_W-1:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = raw[DIGIT_W-1:0];
      co = 1'b0;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  assign invalid = (a > BCD_MAX) || (b > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first, one digit per clock.
// BCD_DIGIT_CHECK_EN enables the sticky invalid-digit flag on err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       a,
  input  logic [4*DIGITS-1:0]       b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [4*DIGITS-1:0]       sum,
  output logic                      cout,
  output logic                      err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_co;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        dig_a = a_q[i*DIGIT_W +: DIGIT_W];
        dig_b = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic dig_invalid;
  logic err_q, err_d;
`endif

  bcd_digit_add u_digit (
    .a       (dig_a),
    .b       (dig_b),
    .ci      (carry_q),
    .s       (dig_s),
    .co      (dig_co)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .invalid (dig_invalid)
`endif
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
`ifdef BCD_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*DIGIT_W +: DIGIT_W] = dig_s;
        end
        carry_d = dig_co;
        idx_d   = idx_q + IDX_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q | dig_invalid;
`endif
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): decimal-arithmetic model plus directed vectors.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand-level model: plain decimal arithmetic on the BCD values.
  function automatic bit all_valid(input logic [W-1:0] v);
    logic [W-1:0] t = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[3:0] > 4'd9) return 1'b0;
      t = t >> 4;
    end
    return 1'b1;
  endfunction

  function automatic longint to_dec(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'((v >> (4 * i)) & 16'hF);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (W'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  int           phase = 0;
  logic [W-1:0] m_sum = '0, p_sum;
  logic         m_cout = 1'b0, p_cout;
  logic         m_err = 1'b0, p_err;
  bit           m_known = 1'b1, p_known;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; m_sum = '0; m_cout = 1'b0; m_err = 1'b0; m_known = 1'b1;
    end else if (phase == 0) begin
      if (start) begin
        longint total, lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        p_known = all_valid(a) && all_valid(b);
        total   = to_dec(a) + to_dec(b) + longint'(cin);
        p_sum   = to_bcd(total % lim);
        p_cout  = (total >= lim);
`ifdef BCD_DIGIT_CHECK_EN
        p_err   = !p_known;
`else
        p_err   = 1'b0;
`endif
        m_sum = '0; m_cout = 1'b0; m_err = 1'b0; m_known = 1'b1;
        phase = 1;
      end
    end else if (phase == DIGITS + 1) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == DIGITS + 1) begin
        m_sum = p_sum; m_cout = p_cout; m_err = p_err; m_known = p_known;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("done", 32'(done), 32'(phase == DIGITS + 1));
      if (phase == 0 || phase == DIGITS + 1) begin
        chk("err", 32'(err), 32'(m_err));
        if (m_known) begin
          chk("sum", 32'(sum), 32'(m_sum));
          chk("cout", 32'(cout), 32'(m_cout));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; cyc counts negedges since the start edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic [W-1:0] es, input logic ec);
    int cyc;
    issue(ia, ib, ic);
    wait_done(cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'd5);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    run_op("basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);
    chk("basic_err", 32'(err), 32'd0);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("max", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    run_op("5555", 16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1);

    // Second start two cycles into an operation must be ignored.
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    a = 16'h8888; b = 16'h8888; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ignored_sum", 32'(sum), 32'h3333);
    chk("ignored_cout", 32'(cout), 32'd0);
    issue(16'h0500, 16'h0600, 1'b0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_sum_clr", 32'(sum), 32'd0);
    wait_done(cyc);
    chk("restart_sum", 32'(sum), 32'h1100);
    chk("restart_cout", 32'(cout), 32'd0);

    // Reset sampled at the end of the third ADD cycle.
    issue(16'h9999, 16'h9999, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

    // Digit 1 = A: 10 wraps to 0 with carry, giving 0x0100 either way.
    run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
    chk("invalid_err", 32'(err), 32'd1);
`else
    chk("invalid_err", 32'(err), 32'd0);
`endif
    issue(16'h4321, 16'h1234, 1'b0);
    chk("err_cleared", 32'(err), 32'd0);
    wait_done(cyc);
    chk("after_err_sum", 32'(sum), 32'h5555);
    chk("after_err_err", 32'(err), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Digit-serial, multi-digit BCD adder that processes one decimal digit per clock, least significant digit first. Operands are latched on a start/busy/done handshake. It is the parametrised successor to the single-digit BCD adder and the arithmetic core for multi-digit decimal counters and calculators. Area is traded for latency: one digit adder is reused DIGITS times.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); datapath width is 4*DIGITS bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; accepted only in IDLE
a  input  4*DIGITS  BCD operand A; digit i = a[4i+3:4i]
b  input  4*DIGITS  BCD operand B
cin  input  1  decimal carry-in
busy  output  1  high while an operation is in progress (ADD or DONE)
done  output  1  one-cycle pulse when sum/cout are valid
sum  output  4*DIGITS  BCD result, registered
cout  output  1  decimal carry-out, registered
err  output  1  invalid-digit flag (see Optional Feature)

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high. While rst is sampled high at a clk edge: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit index=0, internal carry=0. Reset mid-operation aborts the operation with no partial result kept.
- States:
  - IDLE: wait for start. On an edge with start=1, latch a, b and cin (into carry). Clear sum, cout and err. Set idx=0 and go to ADD.
  - ADD: each edge processes digit idx.
    - s = a_idx + b_idx + carry, computed as a 5-bit value.
    - If s>9: digit = (s+6)[3:0], carry=1. Otherwise digit = s[3:0], carry=0.
    - Write the digit into sum[4idx+3:4idx], then idx++.
    - After the edge that processes digit DIGITS-1: cout=carry and go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- Timing: for a start sampled at edge E:
  - busy is high from E+1 through the edge E+DIGITS+1.
  - done is high in the cycle between E+DIGITS and E+DIGITS+1.
  - Latency start-to-done is DIGITS+1 cycles. The earliest next start is accepted at E+DIGITS+1.
- start while busy is ignored, including start during DONE. Operand changes after the latch edge have no effect.
- sum and cout hold their value after done until the next accepted start.
- DIGITS=1 is legal: ADD lasts one cycle.
- Maximum result is 99..9 + 99..9 + 1, giving sum=99..9 and cout=1. Correction is always applied modulo 16.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined: in ADD, if a_idx>9 or b_idx>9, err is set. err is sticky until the next accepted start or reset. The addition still completes with standard correction, and done still pulses.
- Undefined: err is tied to 0 and no check logic is built. Invalid digits are processed with the same correction rule, producing an undefined decimal meaning.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9, BCD_CORR=4'd6.
  - State encoding constants ST_IDLE, ST_ADD, ST_DONE (2 bits).
- Sub-module bcd_digit_add: combinational single-digit add.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, and invalid (used only under BCD_DIGIT_CHECK_EN).
  - Instantiated once. The top holds the FSM, digit mux, index counter and result register.

Test Plan (DIGITS=4):
- Basic add: start with a=0x1234, b=0x5678, cin=0 -> done 5 cycles after the start edge, sum=0x6912, cout=0, err=0.
- Full carry ripple: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- Carry-in only: a=0, b=0, cin=1 -> sum=0x0001, cout=0. Also 0x5555+0x4445 -> sum=0x0000, cout=1.
- Handshake: pulse start again 2 cycles after an accepted start with different operands -> ignored, first result unchanged. Start on the cycle after done -> accepted, busy rises, sum clears.
- Reset mid-op: assert rst on the 3rd ADD cycle -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE. A following start/add of 0x0001+0x0002 gives 0x0003.
- With BCD_DIGIT_CHECK_EN: a=0x00A0, b=0x0000 -> err=1 at done, done still pulses. The next valid start clears err. Without the macro, err stays 0 for the same stimulus.
